// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ssd_scan_ctrl
// Desc    : Two-digit seven-segment scan controller with UART character intake
//           and a blanking gap at every digit switch.
// Rev     : 1.0  initial release
// ============================================================================
module ssd_scan_ctrl #(
  parameter int REFRESH_TICKS = 100000,
  parameter int BLANK_TICKS   = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       ck_rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [6:0] seg,
  output logic       digit,
  output logic [3:0] led
);

  localparam int c_max_ticks = (REFRESH_TICKS > BLANK_TICKS) ? REFRESH_TICKS : BLANK_TICKS;
  localparam int c_cnt_w     = $clog2(c_max_ticks);

  localparam logic [c_cnt_w-1:0] c_refresh_last = c_cnt_w'(REFRESH_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last   = c_cnt_w'(BLANK_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

  // State codes double as the led[3:2] status code and follow scan order.
  localparam logic [1:0] c_st_show0  = 2'b00;
  localparam logic [1:0] c_st_blank0 = 2'b01;
  localparam logic [1:0] c_st_show1  = 2'b10;
  localparam logic [1:0] c_st_blank1 = 2'b11;

  localparam logic [4:0] c_code_dash  = 5'd16;
  localparam logic [4:0] c_code_blank = 5'd17;

  localparam logic [1:0] c_kind_shift = 2'd0;
  localparam logic [1:0] c_kind_clear = 2'd1;
  localparam logic [1:0] c_kind_bad   = 2'd2;

  logic                r_ready;
  logic                r_toggle;
  logic                r_bad;
  logic [4:0]          r_left;
  logic [4:0]          r_right;
  logic [1:0]          r_state;
  logic [1:0]          r_led_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [6:0]          r_seg;
  logic                r_digit;

  logic                w_accept;
  logic [1:0]          w_kind;
  logic [4:0]          w_code;
  logic                w_phase_last;
  logic [1:0]          w_state_next;

  function automatic logic [6:0] f_seg_pattern(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'b0111111;
      5'd1:    pat = 7'b0000110;
      5'd2:    pat = 7'b1011011;
      5'd3:    pat = 7'b1001111;
      5'd4:    pat = 7'b1100110;
      5'd5:    pat = 7'b1101101;
      5'd6:    pat = 7'b1111101;
      5'd7:    pat = 7'b0000111;
      5'd8:    pat = 7'b1111111;
      5'd9:    pat = 7'b1101111;
      5'd10:   pat = 7'b1110111;
      5'd11:   pat = 7'b1111100;
      5'd12:   pat = 7'b0111001;
      5'd13:   pat = 7'b1011110;
      5'd14:   pat = 7'b1111001;
      5'd15:   pat = 7'b1110001;
      5'd16:   pat = 7'b1000000;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  assign w_accept = char_valid & r_ready;

  always_comb begin
    w_kind = c_kind_bad;
    w_code = c_code_blank;
    if (char_data >= 8'h30 && char_data <= 8'h39) begin
      w_kind = c_kind_shift;
      w_code = {1'b0, char_data[3:0]};
    end else if ((char_data >= 8'h41 && char_data <= 8'h46) ||
                 (char_data >= 8'h61 && char_data <= 8'h66)) begin
      // Letters a..f sit at xxxx_x001..x110, so 8 + low bits + 1 gives 10..15.
      w_kind = c_kind_shift;
      w_code = {2'b01, char_data[2:0]} + 5'd1;
    end else if (char_data == 8'h2D) begin
      w_kind = c_kind_shift;
      w_code = c_code_dash;
    end else if (char_data == 8'h20) begin
      w_kind = c_kind_clear;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_ready  <= 1'b0;
      r_toggle <= 1'b0;
      r_bad    <= 1'b0;
      r_left   <= c_code_blank;
      r_right  <= c_code_blank;
    end else begin
      r_ready <= ~w_accept;
      if (w_accept) begin
        r_toggle <= ~r_toggle;
        case (w_kind)
          c_kind_shift: begin
            r_left  <= r_right;
            r_right <= w_code;
            r_bad   <= 1'b0;
          end
          c_kind_clear: begin
            r_left  <= c_code_blank;
            r_right <= c_code_blank;
            r_bad   <= 1'b0;
          end
          default: r_bad <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    w_phase_last = 1'b0;
    w_state_next = r_state;
    case (r_state)
      c_st_show0: begin
        w_phase_last = (r_cnt == c_refresh_last);
        if (w_phase_last) w_state_next = c_st_blank0;
      end
      c_st_blank0: begin
        w_phase_last = (r_cnt == c_blank_last);
        if (w_phase_last) w_state_next = c_st_show1;
      end
      c_st_show1: begin
        w_phase_last = (r_cnt == c_refresh_last);
        if (w_phase_last) w_state_next = c_st_blank1;
      end
      default: begin
        w_phase_last = (r_cnt == c_blank_last);
        if (w_phase_last) w_state_next = c_st_show0;
      end
    endcase
  end

  // The segment register itself is the latched digit: loaded once on SHOW
  // entry from the pre-accept buffer and held for the whole phase.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_state     <= c_st_blank1;
      r_led_state <= 2'b00;
      r_cnt       <= '0;
      r_seg       <= 7'b0000000;
      r_digit     <= 1'b0;
    end else begin
      r_led_state <= w_state_next;
      if (w_phase_last) begin
        r_state <= w_state_next;
        r_cnt   <= '0;
        case (w_state_next)
          c_st_show0: begin
            r_seg   <= f_seg_pattern(r_right);
            r_digit <= 1'b0;
          end
          c_st_show1: begin
            r_seg   <= f_seg_pattern(r_left);
            r_digit <= 1'b1;
          end
          default: r_seg <= 7'b0000000;
        endcase
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign char_ready = r_ready;
  assign seg        = r_seg;
  assign digit      = r_digit;
  assign led        = {r_led_state, r_bad, r_toggle};

endmodule
`default_nettype wire
